// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, shift, rotate, load, sync set/clear,
// plus a saturating count of serial bits shifted in since the last load/set/clear.
module univ_shift_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CW        = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIR,
  input  logic             SIL,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic [CW-1:0]    CNT,
  output logic             FULL
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_SET  = 3'b110;
  localparam logic [2:0] MODE_ZERO = 3'b111;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_inc;

  // Both shift directions count toward the serial fill; the count sticks at WIDTH.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);

  always_comb begin
    q_next   = q_reg;
    cnt_next = cnt_reg;
    if (EN) begin
      case (MODE)
        MODE_HOLD: begin
          q_next   = q_reg;
          cnt_next = cnt_reg;
        end
        MODE_SHR: begin
          q_next   = {SIR, q_reg[WIDTH-1:1]};
          cnt_next = cnt_inc;
        end
        MODE_SHL: begin
          q_next   = {q_reg[WIDTH-2:0], SIL};
          cnt_next = cnt_inc;
        end
        MODE_ROR: q_next = {q_reg[0], q_reg[WIDTH-1:1]};
        MODE_ROL: q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
        MODE_LOAD: begin
          q_next   = D;
          cnt_next = '0;
        end
        MODE_SET: begin
          q_next   = '1;
          cnt_next = '0;
        end
        MODE_ZERO: begin
          q_next   = '0;
          cnt_next = '0;
        end
        default: begin
          q_next   = q_reg;
          cnt_next = cnt_reg;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      q_reg   <= RESET_VAL;
      cnt_reg <= '0;
    end else begin
      q_reg   <= q_next;
      cnt_reg <= cnt_next;
    end
  end

  // Outputs are decoded from registered state only, so nothing passes straight through.
  assign Q    = q_reg;
  assign SOR  = q_reg[0];
  assign SOL  = q_reg[WIDTH-1];
  assign CNT  = cnt_reg;
  assign FULL = (cnt_reg == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: a 4-bit instance driven from a vector table,
// and an 8-bit instance with a non-zero reset value for fill/saturation checks.
`timescale 1ns/1ps
module tb_univ_shift_reg;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [3:0] d;
    logic       sir;
    logic       sil;
    logic [3:0] exp_q;
    logic [2:0] exp_cnt;
    logic       exp_full;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic [2:0] mode;
  logic [3:0] d;
  logic       sir;
  logic       sil;
  logic [3:0] q;
  logic       sor;
  logic       sol;
  logic [2:0] cnt;
  logic       full;

  logic       en8;
  logic [2:0] mode8;
  logic [7:0] d8;
  logic       sir8;
  logic       sil8;
  logic [7:0] q8;
  logic       sor8;
  logic       sol8;
  logic [3:0] cnt8;
  logic       full8;

  int num_checks   = 0;
  int num_failures = 0;

  vec_t vecs[24];

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) dut4 (
    .CLK(clk), .CLR(clr), .EN(en), .MODE(mode), .D(d), .SIR(sir), .SIL(sil),
    .Q(q), .SOR(sor), .SOL(sol), .CNT(cnt), .FULL(full)
  );

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'b0000_0101)) dut8 (
    .CLK(clk), .CLR(clr), .EN(en8), .MODE(mode8), .D(d8), .SIR(sir8), .SIL(sil8),
    .Q(q8), .SOR(sor8), .SOL(sol8), .CNT(cnt8), .FULL(full8)
  );

  task automatic checkField(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_q,
                             input logic [2:0] exp_cnt, input logic exp_full);
    checkField({name, " Q"},    32'(q),    32'(exp_q));
    checkField({name, " SOR"},  32'(sor),  32'(exp_q[0]));
    checkField({name, " SOL"},  32'(sol),  32'(exp_q[3]));
    checkField({name, " CNT"},  32'(cnt),  32'(exp_cnt));
    checkField({name, " FULL"}, 32'(full), 32'(exp_full));
  endtask

  task automatic checkOutput8(input string name, input logic [7:0] exp_q,
                              input logic [3:0] exp_cnt, input logic exp_full);
    checkField({name, " Q8"},    32'(q8),    32'(exp_q));
    checkField({name, " SOR8"},  32'(sor8),  32'(exp_q[0]));
    checkField({name, " SOL8"},  32'(sol8),  32'(exp_q[7]));
    checkField({name, " CNT8"},  32'(cnt8),  32'(exp_cnt));
    checkField({name, " FULL8"}, 32'(full8), 32'(exp_full));
  endtask

  task automatic applyStimulus(input logic en_i, input logic [2:0] mode_i,
                               input logic [3:0] d_i, input logic sir_i, input logic sil_i);
    @(negedge clk);
    en   = en_i;
    mode = mode_i;
    d    = d_i;
    sir  = sir_i;
    sil  = sil_i;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp8;
    logic [7:0] ones8;
    logic [7:0] rv8;

    //              en  mode    d        sir   sil   exp_q    cnt full
    vecs[0]  = '{1'b1, 3'b101, 4'b1011, 1'b0, 1'b0, 4'b1011, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 3'b011, 4'b0000, 1'b0, 1'b0, 4'b1101, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 3'b100, 4'b0000, 1'b0, 1'b0, 4'b1011, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 3'b100, 4'b0000, 1'b0, 1'b0, 4'b0111, 3'd0, 1'b0};
    vecs[4]  = '{1'b1, 3'b111, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0};
    vecs[5]  = '{1'b1, 3'b001, 4'b0000, 1'b1, 1'b0, 4'b1000, 3'd1, 1'b0};
    vecs[6]  = '{1'b1, 3'b001, 4'b0000, 1'b0, 1'b0, 4'b0100, 3'd2, 1'b0};
    vecs[7]  = '{1'b1, 3'b001, 4'b0000, 1'b1, 1'b0, 4'b1010, 3'd3, 1'b0};
    vecs[8]  = '{1'b1, 3'b001, 4'b0000, 1'b1, 1'b0, 4'b1101, 3'd4, 1'b1};
    vecs[9]  = '{1'b1, 3'b001, 4'b0000, 1'b0, 1'b0, 4'b0110, 3'd4, 1'b1};
    vecs[10] = '{1'b1, 3'b011, 4'b0000, 1'b0, 1'b0, 4'b0011, 3'd4, 1'b1};
    vecs[11] = '{1'b1, 3'b111, 4'b0000, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0};
    vecs[12] = '{1'b1, 3'b010, 4'b0000, 1'b0, 1'b1, 4'b0001, 3'd1, 1'b0};
    vecs[13] = '{1'b1, 3'b010, 4'b0000, 1'b0, 1'b1, 4'b0011, 3'd2, 1'b0};
    vecs[14] = '{1'b1, 3'b010, 4'b0000, 1'b0, 1'b0, 4'b0110, 3'd3, 1'b0};
    vecs[15] = '{1'b1, 3'b110, 4'b0000, 1'b0, 1'b0, 4'b1111, 3'd0, 1'b0};
    vecs[16] = '{1'b1, 3'b101, 4'b0010, 1'b0, 1'b0, 4'b0010, 3'd0, 1'b0};
    vecs[17] = '{1'b0, 3'b001, 4'b0000, 1'b1, 1'b0, 4'b0010, 3'd0, 1'b0};
    vecs[18] = '{1'b0, 3'b001, 4'b0000, 1'b1, 1'b0, 4'b0010, 3'd0, 1'b0};
    vecs[19] = '{1'b0, 3'b001, 4'b0000, 1'b1, 1'b0, 4'b0010, 3'd0, 1'b0};
    vecs[20] = '{1'b1, 3'b001, 4'b0000, 1'b1, 1'b0, 4'b1001, 3'd1, 1'b0};
    vecs[21] = '{1'b1, 3'b010, 4'b0000, 1'b0, 1'b0, 4'b0010, 3'd2, 1'b0};
    vecs[22] = '{1'b1, 3'b000, 4'b0000, 1'b1, 1'b1, 4'b0010, 3'd2, 1'b0};
    vecs[23] = '{1'b0, 3'b101, 4'b1111, 1'b0, 1'b0, 4'b0010, 3'd2, 1'b0};

    clr   = 1'b1;
    en    = 1'b0;
    mode  = 3'b000;
    d     = 4'b0000;
    sir   = 1'b0;
    sil   = 1'b0;
    en8   = 1'b0;
    mode8 = 3'b000;
    d8    = 8'h00;
    sir8  = 1'b0;
    sil8  = 1'b0;

    // Reset held across running clock edges
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 4'b0000, 3'd0, 1'b0);
    checkOutput8("reset", 8'b0000_0101, 4'd0, 1'b0);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sir, vecs[i].sil);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_full);
    end

    // Asynchronous clear in the middle of a cycle, after a shift has bumped CNT
    applyStimulus(1'b1, 3'b101, 4'b1010, 1'b0, 1'b0);
    checkOutput("pre_clr", 4'b1010, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'b001, 4'b0000, 1'b1, 1'b0);
    checkOutput("pre_clr_shr", 4'b1101, 3'd1, 1'b0);
    applyStimulus(1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);
    #2;
    clr = 1'b1;
    #1;
    checkOutput("async_clr", 4'b0000, 3'd0, 1'b0);
    checkOutput8("async_clr", 8'b0000_0101, 4'd0, 1'b0);
    @(negedge clk);
    clr = 1'b0;

    // Wide instance: fill with ones from the reset value, then saturate
    ones8 = 8'hFF;
    rv8   = 8'b0000_0101;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      en8   = 1'b1;
      mode8 = 3'b001;
      sir8  = 1'b1;
      @(posedge clk);
      #1;
      if (i <= 8) exp8 = (ones8 << (8 - i)) | (rv8 >> i);
      else        exp8 = ones8;
      checkOutput8($sformatf("fill%0d", i), exp8, (i >= 8) ? 4'd8 : 4'(i), (i >= 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_failures);
    $finish;
  end

endmodule
